sram_like_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the fetch requester (inst side) and the mem-stage requester (data side, driven by m_data_req/wr/size/addr/wdata).
- Sits between the pipeline and the cache/AXI bridge.
- Carries one outstanding transaction at a time.
- Fixed data-over-inst priority unless round-robin is compiled in.

---
 rtl/sram_like_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like bus port between an instruction
// requester and a data requester, one outstanding transaction at a time.
// Default build grants data over inst; defining ARB_RR_EN alternates the
// grant between the two sides when both request in the same IDLE cycle.
module sram_like_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_wr,
   input  logic [1:0]        i_size,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              i_addr_ok,
   output logic              i_data_ok,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_addr_ok,
   output logic              d_data_ok,
   output logic [DATA_W-1:0] d_rdata,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              grant_data;
   logic              addr_done;
   logic              data_done;
`ifdef ARB_RR_EN
   logic              last_winner_q, last_winner_d;
`endif

   // Pick the winner for an IDLE-cycle decision (1 = data side).
   always_comb begin
      grant_data = 1'b0;
`ifdef ARB_RR_EN
      if (d_req && i_req) begin
         grant_data = (last_winner_q == OWN_INST);
      end else begin
         grant_data = d_req;
      end
`else
      grant_data = d_req;
`endif
   end

   // Next-state, owner and request latch; the bus only sees latched fields.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef ARB_RR_EN
      last_winner_d = last_winner_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (d_req || i_req) begin
               state_d = S_ADDR;
               if (grant_data) begin
                  owner_d = OWN_DATA;
                  wr_d    = d_wr;
                  size_d  = d_size;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
               end else begin
                  owner_d = OWN_INST;
                  wr_d    = i_wr;
                  size_d  = i_size;
                  addr_d  = i_addr;
                  wdata_d = i_wdata;
               end
`ifdef ARB_RR_EN
               last_winner_d = grant_data ? OWN_DATA : OWN_INST;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            if (bus_addr_ok) begin
               state_d = bus_data_ok ? S_IDLE : S_DATA;
            end else begin
               state_d = S_ADDR;
            end
         end
         S_DATA: begin
            if (bus_data_ok) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DATA;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latch registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= OWN_DATA;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef ARB_RR_EN
         last_winner_q <= OWN_INST;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef ARB_RR_EN
         last_winner_q <= last_winner_d;
`endif
      end
   end

   // Handshake strobes: completions outside ADDR/DATA are stray and ignored.
   always_comb begin
      addr_done = (state_q == S_ADDR) && bus_addr_ok;
      data_done = ((state_q == S_ADDR) && bus_addr_ok && bus_data_ok) ||
                  ((state_q == S_DATA) && bus_data_ok);
      i_addr_ok = addr_done && (owner_q == OWN_INST);
      d_addr_ok = addr_done && (owner_q == OWN_DATA);
      i_data_ok = data_done && (owner_q == OWN_INST);
      d_data_ok = data_done && (owner_q == OWN_DATA);
   end

   assign bus_req   = (state_q == S_ADDR);
   assign bus_wr    = wr_q;
   assign bus_size  = size_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign busy      = (state_q != S_IDLE);
   assign i_rdata   = bus_rdata;
   assign d_rdata   = bus_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter; expected grant order depends on ARB_RR_EN.
module tb_sram_like_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_wr;
   logic [1:0]  i_size;
   logic [31:0] i_addr, i_wdata;
   logic        i_addr_ok, i_data_ok;
   logic [31:0] i_rdata;
   logic        d_req, d_wr;
   logic [1:0]  d_size;
   logic [31:0] d_addr, d_wdata;
   logic        d_addr_ok, d_data_ok;
   logic [31:0] d_rdata;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_addr_ok, bus_data_ok;
   logic [31:0] bus_rdata;
   logic        busy;

   int checks = 0;
   int failures = 0;

   sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Settle combinational outputs before sampling.
   task automatic settle();
      #2;
   endtask

   logic exp_d;

   initial begin
      rst = 1'b1;
      i_req = 1'b0; i_wr = 1'b0; i_size = 2'd0; i_addr = 32'h0; i_wdata = 32'h0;
      d_req = 1'b0; d_wr = 1'b0; d_size = 2'd0; d_addr = 32'h0; d_wdata = 32'h0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
      tick(); tick();
      settle();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_strobes", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      rst = 1'b0;
      tick();

      // Inst read, addr_ok at cycle 2, data_ok at cycle 4.
      i_req = 1'b1; i_addr = 32'hBFC00000; i_size = 2'd2;
      settle();
      chk("t1_c0_bus_req", {31'd0, bus_req}, 32'd0);
      tick();
      i_addr = 32'h11111111;
      settle();
      chk("t1_c1_bus_req", {31'd0, bus_req}, 32'd1);
      chk("t1_c1_bus_addr", bus_addr, 32'hBFC00000);
      chk("t1_c1_bus_wr", {31'd0, bus_wr}, 32'd0);
      chk("t1_c1_i_addr_ok", {31'd0, i_addr_ok}, 32'd0);
      tick();
      bus_addr_ok = 1'b1;
      settle();
      chk("t1_c2_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd2);
      chk("t1_c2_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
      tick();
      bus_addr_ok = 1'b0; i_req = 1'b0;
      settle();
      chk("t1_c3_busy", {31'd0, busy}, 32'd1);
      chk("t1_c3_bus_req", {31'd0, bus_req}, 32'd0);
      chk("t1_c3_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'h3C080000;
      settle();
      chk("t1_c4_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd2);
      chk("t1_c4_i_rdata", i_rdata, 32'h3C080000);
      tick();
      bus_data_ok = 1'b0;
      settle();
      chk("t1_c5_busy", {31'd0, busy}, 32'd0);
      chk("t1_c5_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);

      // Contention: data write wins, inst served after one IDLE cycle.
      d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h80001000; d_wdata = 32'h12345678;
      i_req = 1'b1; i_addr = 32'hBFC00004;
      tick();
      bus_addr_ok = 1'b1;
      settle();
      chk("t2_bus_addr", bus_addr, 32'h80001000);
      chk("t2_bus_wr", {31'd0, bus_wr}, 32'd1);
      chk("t2_bus_wdata", bus_wdata, 32'h12345678);
      chk("t2_bus_size", {30'd0, bus_size}, 32'd2);
      chk("t2_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd1);
      tick();
      d_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      settle();
      chk("t2_d_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd1);
      tick();
      bus_data_ok = 1'b0;
      settle();
      chk("t2_idle_gap_busy", {31'd0, busy}, 32'd0);
      chk("t2_idle_gap_bus_req", {31'd0, bus_req}, 32'd0);
      tick();
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
      settle();
      chk("t2_inst_bus_addr", bus_addr, 32'hBFC00004);
      chk("t2_inst_bus_wr", {31'd0, bus_wr}, 32'd0);
      chk("t2_inst_strobes", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'hC);
      tick();
      i_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      settle();
      chk("t2_end_busy", {31'd0, busy}, 32'd0);

      // Zero-latency data read.
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h80002000;
      tick();
      d_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
      settle();
      chk("t3_strobes", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h3);
      chk("t3_bus_addr", bus_addr, 32'h80002000);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      settle();
      chk("t3_next_busy", {31'd0, busy}, 32'd0);

      // Stray completion while IDLE.
      bus_data_ok = 1'b1;
      settle();
      chk("t4_idle_stray_strobes", {30'd0, i_data_ok, d_data_ok}, 32'd0);
      tick();
      bus_data_ok = 1'b0;
      settle();
      chk("t4_idle_stray_busy", {31'd0, busy}, 32'd0);

      // Stray completion in ADDR without addr_ok, then reset in DATA.
      d_req = 1'b1; d_addr = 32'h80003000;
      tick();
      d_req = 1'b0; bus_data_ok = 1'b1;
      settle();
      chk("t4_addr_stray_strobes", {30'd0, i_data_ok, d_data_ok}, 32'd0);
      tick();
      bus_data_ok = 1'b0;
      settle();
      chk("t4_addr_stray_still_addr", {31'd0, bus_req}, 32'd1);
      bus_addr_ok = 1'b1;
      settle();
      chk("t5_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd1);
      tick();
      bus_addr_ok = 1'b0; rst = 1'b1;
      settle();
      chk("t5_in_data_busy", {31'd0, busy}, 32'd1);
      tick();
      rst = 1'b0;
      settle();
      chk("t5_after_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_after_rst_bus_addr", bus_addr, 32'h0);
      tick();
      bus_data_ok = 1'b1;
      settle();
      chk("t5_late_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
      chk("t5_late_busy", {31'd0, busy}, 32'd0);
      tick();
      bus_data_ok = 1'b0;

      // Grant order with both sides requesting continuously.
      d_req = 1'b1; i_req = 1'b1; d_addr = 32'h80004000; i_addr = 32'hBFC00008;
      for (int k = 0; k < 4; k++) begin
         tick();
         bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
         settle();
`ifdef ARB_RR_EN
         exp_d = (k % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         chk($sformatf("t6_grant%0d", k), {30'd0, i_addr_ok, d_addr_ok}, {30'd0, ~exp_d, exp_d});
         chk($sformatf("t6_addr%0d", k), bus_addr, exp_d ? 32'h80004000 : 32'hBFC00008);
         tick();
         bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
         settle();
         chk($sformatf("t6_idle%0d", k), {31'd0, busy}, 32'd0);
      end
      d_req = 1'b0; i_req = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
